// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory burst arbiter.
//   - ADDR_W_DEF / DATA_W_DEF / LEN_W_DEF : default bus widths
//   - BEAT_BYTES                          : byte stride between burst beats
//   - state_t                             : arbiter FSM encoding
//   - port_id_t                           : requester identity (p0 / p1)
package dmem_arb_pkg;

   localparam int unsigned ADDR_W_DEF = 10;
   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned LEN_W_DEF  = 4;
   localparam int unsigned BEAT_BYTES = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_BURST = 1'b1
   } state_t;

   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_id_t;

   // Port that is not p; used to hand the round-robin pointer over.
   function automatic port_id_t other_port(input port_id_t p);
      return (p == PORT0) ? PORT1 : PORT0;
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports plus the data-memory port.
//   Requester side : pN_req/we/addr/len/wdata in, pN_gnt/rvalid/rdata/done out
//   Memory side    : mem_ReadAddr/mem_WriteAddr/mem_DataIn/mem_regWE out,
//                    mem_DataOut in (combinational read data)
// Modports:
//   slave  - the arbiter (serves the requesters, drives the memory)
//   master - the environment (requesters plus memory model)
interface dmem_arbiter_if #(
   parameter int unsigned ADDR_W = dmem_arb_pkg::ADDR_W_DEF,
   parameter int unsigned DATA_W = dmem_arb_pkg::DATA_W_DEF,
   parameter int unsigned LEN_W  = dmem_arb_pkg::LEN_W_DEF
);

   logic              p0_req;
   logic              p1_req;
   logic              p0_we;
   logic              p1_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [ADDR_W-1:0] p1_addr;
   logic [LEN_W-1:0]  p0_len;
   logic [LEN_W-1:0]  p1_len;
   logic [DATA_W-1:0] p0_wdata;
   logic [DATA_W-1:0] p1_wdata;

   logic              p0_gnt;
   logic              p1_gnt;
   logic              p0_rvalid;
   logic              p1_rvalid;
   logic [DATA_W-1:0] p0_rdata;
   logic [DATA_W-1:0] p1_rdata;
   logic              p0_done;
   logic              p1_done;

   logic [ADDR_W-1:0] mem_ReadAddr;
   logic [ADDR_W-1:0] mem_WriteAddr;
   logic [DATA_W-1:0] mem_DataIn;
   logic              mem_regWE;
   logic [DATA_W-1:0] mem_DataOut;

   modport slave (
      input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_len, p1_len, p0_wdata, p1_wdata, mem_DataOut,
      output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             p0_done, p1_done, mem_ReadAddr, mem_WriteAddr, mem_DataIn,
             mem_regWE
   );

   modport master (
      output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
             p0_len, p1_len, p0_wdata, p1_wdata, mem_DataOut,
      input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata,
             p0_done, p1_done, mem_ReadAddr, mem_WriteAddr, mem_DataIn,
             mem_regWE
   );

endinterface

// File: rtl/rr_pick2.sv
// Two-requester round-robin picker.
//   req[1:0] : request vector, bit N = port N
//   ptr      : port favoured when both request
//   winner   : selected port (PORT0 when nobody requests; caller ignores it)
module rr_pick2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_t   ptr,
   output port_id_t   winner
);

   // Lone requester always wins; the pointer only breaks ties.
   always_comb begin
      winner = PORT0;
      case (req)
         2'b01:   winner = PORT0;
         2'b10:   winner = PORT1;
         2'b11:   winner = ptr;
         default: winner = PORT0;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port burst arbiter in front of a single-ported data memory.
// A burst is accepted in IDLE, then owns the memory for len+1 word beats;
// at least one IDLE cycle separates consecutive bursts.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   bus   : dmem_arbiter_if.slave (requester ports + memory port)
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned LEN_W  = LEN_W_DEF
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);

   state_t            state_q,  state_d;
   port_id_t          owner_q,  owner_d;
   port_id_t          ptr_q,    ptr_d;
   logic              we_q,     we_d;
   logic [ADDR_W-1:0] addr_q,   addr_d;
   logic [LEN_W-1:0]  len_q,    len_d;
   logic [LEN_W-1:0]  cnt_q,    cnt_d;
   logic [DATA_W-1:0] din_q,    din_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              rvalid0_q, rvalid0_d;
   logic              rvalid1_q, rvalid1_d;

   logic [1:0]        req_c;
   port_id_t          win_c;
   logic              burst_c;
   logic              last_c;
   logic              gnt0_c;
   logic              gnt1_c;
   logic [DATA_W-1:0] wdata_c;

   assign req_c   = {bus.p1_req, bus.p0_req};
   assign burst_c = (state_q == ST_BURST);
   assign last_c  = (cnt_q == len_q);
   assign gnt0_c  = burst_c && (owner_q == PORT0);
   assign gnt1_c  = burst_c && (owner_q == PORT1);
   assign wdata_c = (owner_q == PORT1) ? bus.p1_wdata : bus.p0_wdata;

   rr_pick2 u_pick (
      .req    (req_c),
      .ptr    (ptr_q),
      .winner (win_c)
   );

   // Next-state: acceptance in IDLE, beat sequencing and read capture in BURST.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      ptr_d     = ptr_q;
      we_d      = we_q;
      addr_d    = addr_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      din_d     = din_q;
      rdata0_d  = rdata0_q;
      rdata1_d  = rdata1_q;
      rvalid0_d = 1'b0;
      rvalid1_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (|req_c) begin
               state_d = ST_BURST;
               owner_d = win_c;
               cnt_d   = '0;
               if (win_c == PORT1) begin
                  we_d   = bus.p1_we;
                  addr_d = bus.p1_addr;
                  len_d  = bus.p1_len;
               end else begin
                  we_d   = bus.p0_we;
                  addr_d = bus.p0_addr;
                  len_d  = bus.p0_len;
               end
               // Pointer moves only on contention, so a lone requester
               // does not steal the next tie from the other port.
               if (&req_c) begin
                  ptr_d = other_port(win_c);
               end
            end
         end

         ST_BURST: begin
            // Remember the last driven write data so it holds after the burst.
            din_d = wdata_c;
            if (!we_q) begin
               if (owner_q == PORT1) begin
                  rdata1_d  = bus.mem_DataOut;
                  rvalid1_d = 1'b1;
               end else begin
                  rdata0_d  = bus.mem_DataOut;
                  rvalid0_d = 1'b1;
               end
            end
            // Address is not advanced past the final beat so the memory
            // address outputs hold the last beat address while idle.
            if (last_c) begin
               state_d = ST_IDLE;
            end else begin
               cnt_d  = cnt_q + LEN_W'(1);
               addr_d = addr_q + ADDR_W'(BEAT_BYTES);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         owner_q   <= PORT0;
         ptr_q     <= PORT0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         len_q     <= '0;
         cnt_q     <= '0;
         din_q     <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         ptr_q     <= ptr_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         din_q     <= din_d;
         rdata0_q  <= rdata0_d;
         rdata1_q  <= rdata1_d;
         rvalid0_q <= rvalid0_d;
         rvalid1_q <= rvalid1_d;
      end
   end

   // Grant/done/write-enable decode straight from flops, so an async reset
   // clears them (and suppresses any in-flight write) immediately.
   assign bus.p0_gnt        = gnt0_c;
   assign bus.p1_gnt        = gnt1_c;
   assign bus.p0_done       = gnt0_c && last_c;
   assign bus.p1_done       = gnt1_c && last_c;
   assign bus.p0_rvalid     = rvalid0_q;
   assign bus.p1_rvalid     = rvalid1_q;
   assign bus.p0_rdata      = rdata0_q;
   assign bus.p1_rdata      = rdata1_q;
   assign bus.mem_regWE     = burst_c && we_q;
   assign bus.mem_ReadAddr  = {addr_q[ADDR_W-1:2], 2'b00};
   assign bus.mem_WriteAddr = {addr_q[ADDR_W-1:2], 2'b00};
   // Write data must line up with the beat it belongs to, hence the bypass.
   assign bus.mem_DataIn    = burst_c ? wdata_c : din_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: burst write, wrapping read burst,
// round-robin contention, mid-burst reset and a single-beat unaligned read.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int unsigned AW = ADDR_W_DEF;
   localparam int unsigned DW = DATA_W_DEF;
   localparam int unsigned LW = LEN_W_DEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_init;
   logic [31:0] mem [256];
   int          n_total = 0;
   int          n_bad   = 0;

   dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Word-addressed memory model; preload pattern is 0xC0DE0000 | word index.
   assign bus.mem_DataOut = mem[bus.mem_ReadAddr[9:2]];

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      end else if (bus.mem_regWE) begin
         mem[bus.mem_WriteAddr[9:2]] <= bus.mem_DataIn;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [9:0]  t1_addr [4];
   logic [9:0]  t2_addr [4];
   logic [31:0] t2_rd   [4];

   initial begin
      t1_addr = '{10'h010, 10'h014, 10'h018, 10'h01C};
      t2_addr = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
      t2_rd   = '{32'hC0DE_00FE, 32'hC0DE_00FF, 32'hC0DE_0000, 32'hC0DE_0001};

      reset = 1'b1;
      mem_init = 1'b1;
      bus.p0_req = 1'b0; bus.p1_req = 1'b0;
      bus.p0_we = 1'b0;  bus.p1_we = 1'b0;
      bus.p0_addr = '0;  bus.p1_addr = '0;
      bus.p0_len = '0;   bus.p1_len = '0;
      bus.p0_wdata = '0; bus.p1_wdata = '0;

      // Reset state
      tick(); tick();
      chk("rst_p0_gnt", bus.p0_gnt, 0);
      chk("rst_p1_gnt", bus.p1_gnt, 0);
      chk("rst_p0_done", bus.p0_done, 0);
      chk("rst_p1_rvalid", bus.p1_rvalid, 0);
      chk("rst_p0_rdata", bus.p0_rdata, 0);
      chk("rst_we", bus.mem_regWE, 0);
      chk("rst_waddr", bus.mem_WriteAddr, 0);
      chk("rst_din", bus.mem_DataIn, 0);
      mem_init = 1'b0;
      reset = 1'b0;

      // p0 write burst, 4 beats from 0x010
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 10'h010;
      bus.p0_len = 4'd3; bus.p0_wdata = 32'hA0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         bus.p0_req = 1'b0;
         bus.p0_wdata = 32'hA0 + 32'(k - 1);
         #1;
         chk("t1_gnt", bus.p0_gnt, 1);
         chk("t1_p1_gnt", bus.p1_gnt, 0);
         chk("t1_we", bus.mem_regWE, 1);
         chk("t1_waddr", bus.mem_WriteAddr, t1_addr[k-1]);
         chk("t1_raddr", bus.mem_ReadAddr, t1_addr[k-1]);
         chk("t1_din", bus.mem_DataIn, 32'hA0 + 32'(k - 1));
         chk("t1_done", bus.p0_done, (k == 4) ? 1 : 0);
      end
      tick();
      bus.p0_wdata = 32'hFFFF_FFFF;
      #1;
      chk("t1_idle_gnt", bus.p0_gnt, 0);
      chk("t1_idle_we", bus.mem_regWE, 0);
      chk("t1_hold_addr", bus.mem_WriteAddr, 10'h01C);
      chk("t1_hold_din", bus.mem_DataIn, 32'hA3);
      chk("t1_mem4", mem[4], 32'hA0);
      chk("t1_mem5", mem[5], 32'hA1);
      chk("t1_mem6", mem[6], 32'hA2);
      chk("t1_mem7", mem[7], 32'hA3);

      // p1 read burst wrapping past the top of memory
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 10'h3F8; bus.p1_len = 4'd3;
      for (int c = 1; c <= 6; c++) begin
         tick();
         bus.p1_req = 1'b0;
         #1;
         chk("t2_gnt", bus.p1_gnt, (c <= 4) ? 1 : 0);
         chk("t2_p0_gnt", bus.p0_gnt, 0);
         chk("t2_p0_rvalid", bus.p0_rvalid, 0);
         chk("t2_we", bus.mem_regWE, 0);
         chk("t2_done", bus.p1_done, (c == 4) ? 1 : 0);
         if (c <= 4) chk("t2_addr", bus.mem_ReadAddr, t2_addr[c-1]);
         chk("t2_rvalid", bus.p1_rvalid, (c >= 2 && c <= 5) ? 1 : 0);
         if (c >= 2 && c <= 5) chk("t2_rdata", bus.p1_rdata, t2_rd[c-2]);
      end

      // Contention right after reset: p0 first, then p1
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 10'h000; bus.p0_len = 4'd1;
      bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_addr = 10'h100; bus.p1_len = 4'd0;
      tick(); bus.p0_req = 1'b0; #1;
      chk("t3a_c1_p0", bus.p0_gnt, 1);
      chk("t3a_c1_p1", bus.p1_gnt, 0);
      tick();
      chk("t3a_c2_p0", bus.p0_gnt, 1);
      chk("t3a_c2_done", bus.p0_done, 1);
      tick();
      chk("t3a_c3_p0", bus.p0_gnt, 0);
      chk("t3a_c3_p1", bus.p1_gnt, 0);
      tick(); bus.p1_req = 1'b0; #1;
      chk("t3a_c4_p1", bus.p1_gnt, 1);
      chk("t3a_c4_done", bus.p1_done, 1);
      chk("t3a_c4_addr", bus.mem_ReadAddr, 10'h100);
      tick();
      chk("t3a_c5_p1", bus.p1_gnt, 0);
      chk("t3a_c5_rvalid", bus.p1_rvalid, 1);
      chk("t3a_c5_rdata", bus.p1_rdata, 32'hC0DE_0040);
      // Second contention: p1 now favoured
      bus.p0_req = 1'b1; bus.p1_req = 1'b1;
      tick(); bus.p1_req = 1'b0; #1;
      chk("t3b_c1_p1", bus.p1_gnt, 1);
      chk("t3b_c1_p0", bus.p0_gnt, 0);
      tick();
      chk("t3b_c2_p0", bus.p0_gnt, 0);
      chk("t3b_c2_p1", bus.p1_gnt, 0);
      tick(); bus.p0_req = 1'b0; #1;
      chk("t3b_c3_p0", bus.p0_gnt, 1);
      tick();
      chk("t3b_c4_done", bus.p0_done, 1);
      tick();
      chk("t3b_c5_p0", bus.p0_gnt, 0);
      chk("t3b_c5_rdata", bus.p0_rdata, 32'hC0DE_0001);

      // Reset during beat 2 of an 8-beat write
      bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p0_addr = 10'h040;
      bus.p0_len = 4'd7; bus.p0_wdata = 32'h50;
      tick(); bus.p0_req = 1'b0; #1;
      chk("t4_b0_we", bus.mem_regWE, 1);
      chk("t4_b0_addr", bus.mem_WriteAddr, 10'h040);
      tick(); bus.p0_wdata = 32'h51; #1;
      chk("t4_b1_addr", bus.mem_WriteAddr, 10'h044);
      tick(); bus.p0_wdata = 32'h52; #1;
      chk("t4_b2_addr", bus.mem_WriteAddr, 10'h048);
      chk("t4_b2_we", bus.mem_regWE, 1);
      reset = 1'b1;
      #1;
      chk("t4_rst_we", bus.mem_regWE, 0);
      chk("t4_rst_gnt", bus.p0_gnt, 0);
      chk("t4_rst_done", bus.p0_done, 0);
      chk("t4_rst_addr", bus.mem_WriteAddr, 0);
      chk("t4_rst_din", bus.mem_DataIn, 0);
      chk("t4_rst_rdata0", bus.p0_rdata, 0);
      chk("t4_rst_rdata1", bus.p1_rdata, 0);
      tick(); tick();
      reset = 1'b0;
      chk("t4_mem16", mem[16], 32'h50);
      chk("t4_mem17", mem[17], 32'h51);
      chk("t4_mem18", mem[18], 32'hC0DE_0012);
      chk("t4_mem19", mem[19], 32'hC0DE_0013);

      // Single-beat read from an unaligned address, straight after reset
      bus.p0_req = 1'b1; bus.p0_we = 1'b0; bus.p0_addr = 10'h023; bus.p0_len = 4'd0;
      tick(); bus.p0_req = 1'b0; #1;
      chk("t5_gnt", bus.p0_gnt, 1);
      chk("t5_done", bus.p0_done, 1);
      chk("t5_addr", bus.mem_ReadAddr, 10'h020);
      chk("t5_we", bus.mem_regWE, 0);
      tick();
      chk("t5_rvalid", bus.p0_rvalid, 1);
      chk("t5_rdata", bus.p0_rdata, 32'hC0DE_0008);
      chk("t5_gnt_off", bus.p0_gnt, 0);
      tick();
      chk("t5_rvalid_off", bus.p0_rvalid, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
